comb_stack: RTL and testbench
=============================

# comb_stack

LIFO stack that serves the push/pop side of the recursive nCr combination datapath. It stores (n, r) operand pairs pushed by the combination controller and presents the top pair combinationally for the controller's compare and load steps. It reports empty and full to the controller. It is the responder for the controller's push/pop command interface.

## Interface
- `WIDTH`, 4: bit width of each of n and r.
- `DEPTH`, 16: number of (n, r) entries; a power of two, at least 2.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-low reset.
- `push` input 1: write `din_n`/`din_r` as the new top this cycle.
- `pop` input 1: discard the top entry this cycle.
- `din_n`, `din_r` input WIDTH each: pair to push.
- `top_n`, `top_r` output WIDTH each: current top pair; 0 when empty.
- `isEmpty` output 1: no entries held.
- `isFull` output 1: DEPTH entries held.
- `count` output $clog2(DEPTH)+1: number of entries held.
- `err` output 2: sticky {overflow, underflow}; present only per Configuration.

## Operation
- State: entry memory `mem[0..DEPTH-1]` holds packed {n, r}; stack pointer `sp` equals `count`.
- Top view: `top_* = mem[sp-1]` when `sp != 0`, else 0. The view is combinational from registers and has no read latency.
- Push only, not full: `mem[sp] <= {din_n, din_r}` and `sp <= sp+1`.
- Pop only, not empty: `sp <= sp-1`. Memory is untouched.
- Push and pop together, not empty: replace the top, `mem[sp-1] <= din`. `sp` is unchanged.
- Push and pop together, empty: treated as push only, giving `sp = 1`.
- Push while full, without pop: ignored. Memory and `sp` are unchanged; this is overflow.
- Pop while empty, without push: ignored; this is underflow.
- Flags: `isEmpty = (sp == 0)` and `isFull = (sp == DEPTH)`. Both are decoded from registered `sp` and are glitch-free relative to `clk`.
- Reset mid-operation: `sp` returns to 0 immediately, so all entries are logically discarded. Memory contents are not cleared and are never visible, because `top` is forced to 0 when empty.

## Timing
- Reset values:
  - `sp` = 0
  - `isEmpty` = 1
  - `isFull` = 0
  - `count` = 0
  - `top_n` = `top_r` = 0
  - `err` = 2'b00
- A push at edge k makes the pushed pair visible on `top_*`, and updates the flags, after edge k.
- A pop at edge k exposes the next-lower entry after edge k.
- Back-to-back pops are legal every cycle. The controller's pop → pop sequence (pop, then load-and-pop) sees a new top in each cycle.
- No backpressure exists. The controller must check `isFull`/`isEmpty` itself, and illegal requests are dropped silently.

## Configuration
- `COMB_STACK_ERR_EN` defined:
  - `err[1]` sets on push-while-full without pop.
  - `err[0]` sets on pop-while-empty without push.
  - Both bits are sticky until `rst`.
- Not defined: `err` is tied to 2'b00 and no error registers are built. Push/pop behaviour is identical in both builds.

## Structure
- Shared package `comb_pkg` holds:
  - `COMB_W` (default 4) and `COMB_DEPTH` (default 16).
  - typedef `comb_pair_t` as packed {n, r}.
  - Error bit index constants `ERR_OVF` = 1 and `ERR_UDF` = 0.
- Sub-module `comb_stack_mem` is a DEPTH×2·WIDTH register file with one synchronous write port and one asynchronous read port, not reset. Pointer, flags and error logic stay in `comb_stack`.

## Test plan
- **Reset and empty checks:** deassert `rst`, then pop once. Expect `isEmpty`=1, `count`=0, `top`=(0,0). Expect `err`=01 with the macro and 00 without it.
- **Two pushes, two pops:** push (5,2), then push (4,1). Expect top=(4,1) and `count`=2. Pop → top=(5,2). Pop → `isEmpty`=1.
- **Fill to full:** with DEPTH=16, push 16 distinct pairs. Expect `isFull`=1 after the 16th. A 17th push of (9,9) leaves top equal to the 16th pair and `count`=16, and sets `err[1]` when enabled.
- **Simultaneous push and pop:** with 3 entries and top (3,1), assert push (7,3) and pop together. Expect `count`=3 and top=(7,3). The same operation while empty gives `count`=1 and top=(7,3).
- **Reset mid-operation:** after 5 pushes, pulse `rst` low between clock edges. Expect `count`=0, `isEmpty`=1 and `top`=0 immediately, and `err` cleared.
- **Controller-driven run:** compute 4C2 through the combination controller with this stack. `isEmpty` must rise exactly once, at the end, and the result must equal 6.

Source files
------------

// File: rtl/comb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : comb_pkg
//  Brief    : Shared types and constants for the nCr combination datapath
//             and its (n, r) operand stack.
//  Revision : 1.0 - initial release
// ============================================================================
package comb_pkg;

  // Default operand width and stack depth.
  localparam int COMB_W     = 4;
  localparam int COMB_DEPTH = 16;

  // One stack entry: operand pair packed as {n, r}.
  typedef struct packed {
    logic [COMB_W-1:0] n;
    logic [COMB_W-1:0] r;
  } comb_pair_t;

  // Bit positions inside the sticky error vector.
  localparam int ERR_OVF = 1;
  localparam int ERR_UDF = 0;

endpackage : comb_pkg
`default_nettype wire

// File: rtl/comb_stack_if.sv
`default_nettype none
// ============================================================================
//  Module   : comb_stack_if
//  Brief    : Push/pop command interface between the combination controller
//             (master) and the operand stack (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface comb_stack_if
  import comb_pkg::*;
#(
  parameter int WIDTH = COMB_W,
  parameter int DEPTH = COMB_DEPTH
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din_n;
  logic [WIDTH-1:0] din_r;
  logic [WIDTH-1:0] top_n;
  logic [WIDTH-1:0] top_r;
  logic             isEmpty;
  logic             isFull;
  logic [CW-1:0]    count;
  logic [1:0]       err;

  // Controller side: issues commands, observes the top pair and status.
  modport master (
    output push, pop, din_n, din_r,
    input  top_n, top_r, isEmpty, isFull, count, err
  );

  // Stack side: responds to commands.
  modport slave (
    input  push, pop, din_n, din_r,
    output top_n, top_r, isEmpty, isFull, count, err
  );

endinterface : comb_stack_if
`default_nettype wire

// File: rtl/comb_stack_mem.sv
`default_nettype none
// ============================================================================
//  Module   : comb_stack_mem
//  Brief    : DEPTH x 2*WIDTH register file, one synchronous write port and
//             one asynchronous read port. Contents are not reset.
//  Revision : 1.0 - initial release
// ============================================================================
module comb_stack_mem
  import comb_pkg::*;
#(
  parameter int WIDTH = COMB_W,
  parameter int DEPTH = COMB_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wire logic                 clk,
  input  wire logic                 i_we,
  input  wire logic [AW-1:0]        i_waddr,
  input  wire logic [2*WIDTH-1:0]   i_wdata,
  input  wire logic [AW-1:0]        i_raddr,
  output logic      [2*WIDTH-1:0]   o_rdata
);

  logic [2*WIDTH-1:0] r_mem [DEPTH];

  // Single write port; storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : comb_stack_mem
`default_nettype wire

// File: rtl/comb_stack.sv
`default_nettype none
// ============================================================================
//  Module   : comb_stack
//  Brief    : LIFO of (n, r) operand pairs for the recursive nCr datapath.
//             Presents the top pair combinationally, reports empty/full.
//             Optional sticky {overflow, underflow} flags are built when
//             COMB_STACK_ERR_EN is defined; otherwise err reads 2'b00.
//  Revision : 1.0 - initial release
// ============================================================================
module comb_stack
  import comb_pkg::*;
#(
  parameter int WIDTH = COMB_W,
  parameter int DEPTH = COMB_DEPTH
) (
  input  wire logic        clk,
  input  wire logic        rst,
  comb_stack_if.slave      bus
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [PW:0]   c_SP_FULL = DEPTH[PW:0];
  localparam logic [PW:0]   c_SP_ONE  = {{PW{1'b0}}, 1'b1};
  localparam logic [PW-1:0] c_IDX_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [PW:0]        r_sp;
  logic [PW:0]        w_sp_nxt;
  logic               w_empty;
  logic               w_full;
  logic               w_we;
  logic [PW-1:0]      w_top_idx;
  logic [PW-1:0]      w_waddr;
  logic [2*WIDTH-1:0] w_rdata;

  assign w_empty   = (r_sp == '0);
  assign w_full    = (r_sp == c_SP_FULL);

  // Index of the current top; at sp == DEPTH the low bits wrap to DEPTH-1.
  assign w_top_idx = r_sp[PW-1:0] - c_IDX_ONE;

  // Push+pop on a non-empty stack overwrites the top, otherwise write at sp.
  // A push while full without pop is dropped.
  assign w_we      = bus.push & (bus.pop | ~w_full);
  assign w_waddr   = (bus.pop & ~w_empty) ? w_top_idx : r_sp[PW-1:0];

  // Next stack pointer: grow on an effective push, shrink on an effective pop.
  always_comb begin
    w_sp_nxt = r_sp;
    if (bus.push && !bus.pop && !w_full) begin
      w_sp_nxt = r_sp + c_SP_ONE;
    end else if (bus.push && bus.pop && w_empty) begin
      w_sp_nxt = c_SP_ONE;
    end else if (bus.pop && !bus.push && !w_empty) begin
      w_sp_nxt = r_sp - c_SP_ONE;
    end
  end

  // Stack pointer register; reset discards all entries logically.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sp <= '0;
    end else begin
      r_sp <= w_sp_nxt;
    end
  end

  comb_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata ({bus.din_n, bus.din_r}),
    .i_raddr (w_top_idx),
    .o_rdata (w_rdata)
  );

  // Stale memory is never exposed: the view is forced to zero when empty.
  assign bus.top_n   = w_empty ? '0 : w_rdata[2*WIDTH-1:WIDTH];
  assign bus.top_r   = w_empty ? '0 : w_rdata[WIDTH-1:0];
  assign bus.isEmpty = w_empty;
  assign bus.isFull  = w_full;
  assign bus.count   = r_sp;

`ifdef COMB_STACK_ERR_EN
  logic [1:0] r_err;
  logic       w_ovf;
  logic       w_udf;

  assign w_ovf = bus.push & ~bus.pop & w_full;
  assign w_udf = bus.pop & ~bus.push & w_empty;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 2'b00;
    end else begin
      if (w_ovf) begin
        r_err[ERR_OVF] <= 1'b1;
      end
      if (w_udf) begin
        r_err[ERR_UDF] <= 1'b1;
      end
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 2'b00;
`endif

endmodule : comb_stack
`default_nettype wire

// File: tb/tb_comb_stack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_comb_stack
//  Brief    : Self-checking bench for comb_stack against a queue-based LIFO
//             reference model. Follows COMB_STACK_ERR_EN for err expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_comb_stack;
  import comb_pkg::*;

  localparam int W = 4;
  localparam int D = 16;

  logic clk;
  logic rst;

  comb_stack_if #(.WIDTH(W), .DEPTH(D)) bus ();

  comb_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of packed {n, r}, back is the top of stack.
  logic [2*W-1:0] m_q[$];
  logic           m_ovf;
  logic           m_udf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic model_apply(input logic p, input logic q, input logic [W-1:0] n, input logic [W-1:0] r);
    if (p && q) begin
      if (m_q.size() == 0) m_q.push_back({n, r});
      else m_q[m_q.size()-1] = {n, r};
    end else if (p) begin
      if (m_q.size() < D) m_q.push_back({n, r});
      else m_ovf = 1'b1;
    end else if (q) begin
      if (m_q.size() > 0) void'(m_q.pop_back());
      else m_udf = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    logic [2*W-1:0] t;
    logic [1:0]     e;
    t = (m_q.size() > 0) ? m_q[m_q.size()-1] : '0;
`ifdef COMB_STACK_ERR_EN
    e = {m_ovf, m_udf};
`else
    e = 2'b00;
`endif
    chk({tag, ".count"}, 32'(bus.count), 32'(m_q.size()));
    chk({tag, ".empty"}, 32'(bus.isEmpty), 32'(m_q.size() == 0));
    chk({tag, ".full"},  32'(bus.isFull),  32'(m_q.size() == D));
    chk({tag, ".top_n"}, 32'(bus.top_n),   32'(t[2*W-1:W]));
    chk({tag, ".top_r"}, 32'(bus.top_r),   32'(t[W-1:0]));
    chk({tag, ".err"},   32'(bus.err),     32'(e));
  endtask

  // One clocked operation; called and returns 1 time unit after a rising edge.
  task automatic step(input logic p, input logic q, input logic [W-1:0] n, input logic [W-1:0] r,
                      input string tag);
    bus.push  = p;
    bus.pop   = q;
    bus.din_n = n;
    bus.din_r = r;
    @(posedge clk);
    model_apply(p, q, n, r);
    #1;
    check_all(tag);
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  initial begin
    int res;
    int rises;
    int cycles;
    logic [W-1:0] tn;
    logic [W-1:0] tr;

    bus.push = 1'b0; bus.pop = 1'b0; bus.din_n = '0; bus.din_r = '0;
    rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("in_reset");
    rst = 1'b1;
    @(posedge clk); #1;
    check_all("after_reset");

    // Underflow on an empty stack.
    step(1'b0, 1'b1, 4'd0, 4'd0, "pop_empty");

    // Two pushes, two pops.
    step(1'b1, 1'b0, 4'd5, 4'd2, "push52");
    step(1'b1, 1'b0, 4'd4, 4'd1, "push41");
    step(1'b0, 1'b1, 4'd0, 4'd0, "pop1");
    step(1'b0, 1'b1, 4'd0, 4'd0, "pop2");

    // Fill to full, then overflow.
    for (int i = 0; i < D; i++) begin
      step(1'b1, 1'b0, W'(i), W'(D - 1 - i), "fill");
    end
    step(1'b1, 1'b0, 4'd9, 4'd9, "overflow");
    step(1'b1, 1'b1, 4'd6, 4'd6, "full_replace");
    for (int i = 0; i < D; i++) begin
      step(1'b0, 1'b1, 4'd0, 4'd0, "drain");
    end

    // Simultaneous push and pop, non-empty and empty.
    step(1'b1, 1'b0, 4'd1, 4'd1, "s_push1");
    step(1'b1, 1'b0, 4'd2, 4'd0, "s_push2");
    step(1'b1, 1'b0, 4'd3, 4'd1, "s_push3");
    step(1'b1, 1'b1, 4'd7, 4'd3, "s_replace");
    repeat (3) step(1'b0, 1'b1, 4'd0, 4'd0, "s_drain");
    step(1'b1, 1'b1, 4'd7, 4'd3, "s_empty_pp");
    step(1'b0, 1'b1, 4'd0, 4'd0, "s_pop");

    // Asynchronous reset between clock edges.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, W'(i + 2), W'(i), "pre_rst");
    end
    step(1'b1, 1'b0, 4'd0, 4'd0, "pre_rst_extra");
    rst = 1'b0;
    model_reset();
    #1;
    check_all("mid_rst");
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    check_all("post_rst");

    // Controller-style recursive 4C2.
    res = 0; rises = 0; cycles = 0;
    step(1'b1, 1'b0, 4'd4, 4'd2, "ctl_start");
    while (!bus.isEmpty && cycles < 200) begin
      tn = bus.top_n;
      tr = bus.top_r;
      if (tr == 0 || tr == tn) begin
        res++;
        step(1'b0, 1'b1, 4'd0, 4'd0, "ctl_leaf");
        if (bus.isEmpty) rises++;
      end else begin
        step(1'b1, 1'b1, tn - 4'd1, tr - 4'd1, "ctl_split");
        if (bus.isEmpty) rises++;
        step(1'b1, 1'b0, tn - 4'd1, tr, "ctl_push");
        if (bus.isEmpty) rises++;
      end
      cycles++;
    end
    chk("ctl_timeout", 32'(cycles < 200), 32'd1);
    chk("ctl_result", 32'(res), 32'd6);
    chk("ctl_empty_once", 32'(rises), 32'd1);

    // Randomized traffic: bias towards filling, then towards draining.
    for (int i = 0; i < 600; i++) begin
      int pp;
      pp = ((i / 100) % 2 == 0) ? 75 : 25;
      step(($urandom_range(99) < pp) ? 1'b1 : 1'b0,
           ($urandom_range(99) < 100 - pp) ? 1'b1 : 1'b0,
           W'($urandom), W'($urandom), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_comb_stack
`default_nettype wire
